// File: rtl/vid_pixel_feeder_pkg.sv
// Shared types and defaults for the pixel feeder: state encoding,
// default pixel width and blank colour, and counter widths.
package vid_pixel_feeder_pkg;

    typedef enum logic [1:0] {
        ST_SYNC  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FAULT = 2'd2
    } state_t;

    localparam int          DATA_W_DEF    = 24;
    localparam logic [23:0] BLANK_RGB_DEF = 24'h000000;
    localparam int          PIX_CNT_W     = 12;
    localparam int          LINE_CNT_W    = 11;

endpackage

// File: rtl/vid_pixel_feeder_if.sv
// Input side of the pixel feeder: stream-style timing from the VTC stage
// and the read port of the DDR3 read-side line FIFO.
interface vid_pixel_feeder_if
    import vid_pixel_feeder_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF
);
    logic              I_vtc_vs;
    logic              I_vtc_hs;
    logic              I_vtc_de;
    logic              I_vtc_user;
    logic              I_vtc_last;
    logic              O_fifo_rd;
    logic [DATA_W-1:0] I_fifo_rdata;
    logic              I_fifo_empty;

    // Feeder view: consumes timing and FIFO data, drives the read strobe.
    modport slave (
        input  I_vtc_vs, I_vtc_hs, I_vtc_de, I_vtc_user, I_vtc_last,
        input  I_fifo_rdata, I_fifo_empty,
        output O_fifo_rd
    );

    // Upstream view: timing generator plus FIFO.
    modport master (
        output I_vtc_vs, I_vtc_hs, I_vtc_de, I_vtc_user, I_vtc_last,
        output I_fifo_rdata, I_fifo_empty,
        input  O_fifo_rd
    );
endinterface

// File: rtl/vid_pixel_feeder_align_pipe.sv
// Two-stage delay line keeping vs/hs/de aligned with FIFO read data.
// Stage 1 matches the FIFO read latency and carries a tag saying the
// read issued on the previous cycle returned real data.
module vid_pixel_feeder_align_pipe (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_vs,
    input  logic i_hs,
    input  logic i_de,
    input  logic i_rd_vld,
    output logic o_s1_rd_vld,
    output logic o_vs,
    output logic o_hs,
    output logic o_de
);
    logic r_s1_vs, r_s1_hs, r_s1_de, r_s1_rd_vld;
    logic r_s2_vs, r_s2_hs, r_s2_de;

    // Shift timing through both stages; the read tag only needs stage 1.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_s1_vs     <= 1'b0;
            r_s1_hs     <= 1'b0;
            r_s1_de     <= 1'b0;
            r_s1_rd_vld <= 1'b0;
            r_s2_vs     <= 1'b0;
            r_s2_hs     <= 1'b0;
            r_s2_de     <= 1'b0;
        end else begin
            r_s1_vs     <= i_vs;
            r_s1_hs     <= i_hs;
            r_s1_de     <= i_de;
            r_s1_rd_vld <= i_rd_vld;
            r_s2_vs     <= r_s1_vs;
            r_s2_hs     <= r_s1_hs;
            r_s2_de     <= r_s1_de;
        end
    end

    assign o_s1_rd_vld = r_s1_rd_vld;
    assign o_vs        = r_s2_vs;
    assign o_hs        = r_s2_hs;
    assign o_de        = r_s2_de;
endmodule

// File: rtl/vid_pixel_feeder.sv
// Pixel feeder: pops one FIFO word per active pixel, aligns it with the
// delayed timing and blanks the output after any underflow or length
// error until the next frame start.
//
//   state    | meaning
//   ---------+-----------------------------------------------------------
//   ST_SYNC  | not locked (after reset); waits for user&de to start a frame
//   ST_RUN   | locked; one read per de, line/frame lengths checked
//   ST_FAULT | fault seen; no reads, output blanked until user&de re-locks
module vid_pixel_feeder
    import vid_pixel_feeder_pkg::*;
#(
    parameter int                DATA_W       = DATA_W_DEF,
    parameter int                H_ActiveSize = 1920,
    parameter int                V_ActiveSize = 1080,
    parameter logic [DATA_W-1:0] BLANK_RGB    = DATA_W'(BLANK_RGB_DEF)
) (
    input  logic                I_vid_clk,
    input  logic                I_vid_rst,
    vid_pixel_feeder_if.slave   vtc_fifo,
    output logic                O_frame_req,
    output logic                O_vid_vs,
    output logic                O_vid_hs,
    output logic                O_vid_de,
    output logic [DATA_W-1:0]   O_vid_rgb,
    output logic                O_underflow,
    output logic                O_len_err
);
    localparam logic [PIX_CNT_W-1:0]  L_H = PIX_CNT_W'(H_ActiveSize);
    localparam logic [LINE_CNT_W-1:0] L_V = LINE_CNT_W'(V_ActiveSize);

    state_t                  r_state, w_state_nxt;
    logic [PIX_CNT_W-1:0]    r_pix_cnt;
    logic [LINE_CNT_W-1:0]   r_line_cnt;
    logic                    r_underflow, r_len_err;
    logic                    r_vs_d, r_frame_req;
    logic [DATA_W-1:0]       r_rgb;
    logic                    w_relock, w_rd, w_frame_start, w_underflow;
    logic                    w_pix_len_bad, w_line_len_bad, w_s1_rd_vld;
    logic                    w_run_last;

    assign w_relock   = vtc_fifo.I_vtc_user & vtc_fifo.I_vtc_de;
    assign w_run_last = (r_state == ST_RUN) & vtc_fifo.I_vtc_last;

    // Next state, read strobe and fault detection.
    always_comb begin
        w_state_nxt    = r_state;
        w_rd           = 1'b0;
        w_frame_start  = 1'b0;
        w_pix_len_bad  = 1'b0;
        w_line_len_bad = 1'b0;
        case (r_state)
            ST_SYNC, ST_FAULT: begin
                if (w_relock) begin
                    w_rd          = 1'b1;
                    w_frame_start = 1'b1;
                    w_state_nxt   = ST_RUN;
                end
            end
            ST_RUN: begin
                w_rd = vtc_fifo.I_vtc_de;
                if (w_relock) begin
                    // A short/long frame still re-locks on this user pulse.
                    w_frame_start  = 1'b1;
                    w_line_len_bad = (r_line_cnt != L_V);
                end
                if (vtc_fifo.I_vtc_last && (r_pix_cnt != L_H)) begin
                    w_pix_len_bad = 1'b1;
                    w_state_nxt   = ST_FAULT;
                end
            end
            default: w_state_nxt = ST_SYNC;
        endcase
        // No FIFO traffic while reset is held; state is still stale then.
        if (I_vid_rst) begin
            w_rd = 1'b0;
        end
        w_underflow = w_rd & vtc_fifo.I_fifo_empty;
        if (w_underflow) begin
            w_state_nxt = ST_FAULT;
        end
    end

    // State register.
    always_ff @(posedge I_vid_clk) begin
        if (I_vid_rst) begin
            r_state <= ST_SYNC;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Pixel/line counters and sticky fault flags.
    always_ff @(posedge I_vid_clk) begin
        if (I_vid_rst) begin
            r_pix_cnt   <= '0;
            r_line_cnt  <= '0;
            r_underflow <= 1'b0;
            r_len_err   <= 1'b0;
        end else begin
            // The frame-start read is itself the first pixel of the line.
            if (w_frame_start) begin
                r_pix_cnt <= PIX_CNT_W'(1);
            end else if (w_run_last) begin
                r_pix_cnt <= PIX_CNT_W'(w_rd);
            end else if (w_rd) begin
                r_pix_cnt <= r_pix_cnt + 1'b1;
            end
            if (w_frame_start) begin
                r_line_cnt <= '0;
            end else if (w_run_last) begin
                r_line_cnt <= r_line_cnt + 1'b1;
            end
            r_underflow <= (r_underflow & ~w_frame_start) | w_underflow;
            r_len_err   <= (r_len_err & ~w_frame_start) | w_pix_len_bad | w_line_len_bad;
        end
    end

    // Frame request on the rising edge of vs, in every state.
    always_ff @(posedge I_vid_clk) begin
        if (I_vid_rst) begin
            r_vs_d      <= 1'b0;
            r_frame_req <= 1'b0;
        end else begin
            r_vs_d      <= vtc_fifo.I_vtc_vs;
            r_frame_req <= vtc_fifo.I_vtc_vs & ~r_vs_d;
        end
    end

    vid_pixel_feeder_align_pipe u_align_pipe (
        .i_clk       (I_vid_clk),
        .i_rst       (I_vid_rst),
        .i_vs        (vtc_fifo.I_vtc_vs),
        .i_hs        (vtc_fifo.I_vtc_hs),
        .i_de        (vtc_fifo.I_vtc_de),
        .i_rd_vld    (w_rd & ~vtc_fifo.I_fifo_empty),
        .o_s1_rd_vld (w_s1_rd_vld),
        .o_vs        (O_vid_vs),
        .o_hs        (O_vid_hs),
        .o_de        (O_vid_de)
    );

    // Output pixel register: FIFO data only behind a successful read.
    always_ff @(posedge I_vid_clk) begin
        if (I_vid_rst) begin
            r_rgb <= BLANK_RGB;
        end else begin
            r_rgb <= w_s1_rd_vld ? vtc_fifo.I_fifo_rdata : BLANK_RGB;
        end
    end

    assign vtc_fifo.O_fifo_rd = w_rd;
    assign O_frame_req        = r_frame_req;
    assign O_vid_rgb          = r_rgb;
    assign O_underflow        = r_underflow;
    assign O_len_err          = r_len_err;
endmodule

// File: tb/tb_vid_pixel_feeder.sv
// Directed bench for vid_pixel_feeder with a 4x2 frame geometry.
// FIFO word i holds value i+1, so expected pixels are plain constants.
module tb_vid_pixel_feeder;
    localparam int LOGN = 1024;

    logic clk = 1'b0;
    logic rst;
    logic force_empty;
    int   cyc = 0;
    int   rd_ptr = 0;
    int   wr_cnt = 0;
    int   n_chk = 0;
    int   n_err = 0;

    logic [23:0] mem [0:127];
    logic [23:0] lg_rgb [0:LOGN-1];
    logic        lg_de [0:LOGN-1];
    logic        lg_vs [0:LOGN-1];
    logic        lg_rd [0:LOGN-1];
    logic        lg_uf [0:LOGN-1];
    logic        lg_len [0:LOGN-1];
    logic        lg_freq [0:LOGN-1];

    logic        o_frame_req, o_vid_vs, o_vid_hs, o_vid_de, o_underflow, o_len_err;
    logic [23:0] o_vid_rgb;

    int pix_cyc[$];
    int last_cyc[$];
    int vs_cyc;

    vid_pixel_feeder_if #(.DATA_W(24)) bus ();

    vid_pixel_feeder #(
        .DATA_W       (24),
        .H_ActiveSize (4),
        .V_ActiveSize (2),
        .BLANK_RGB    (24'h000000)
    ) dut (
        .I_vid_clk   (clk),
        .I_vid_rst   (rst),
        .vtc_fifo    (bus),
        .O_frame_req (o_frame_req),
        .O_vid_vs    (o_vid_vs),
        .O_vid_hs    (o_vid_hs),
        .O_vid_de    (o_vid_de),
        .O_vid_rgb   (o_vid_rgb),
        .O_underflow (o_underflow),
        .O_len_err   (o_len_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // FIFO model: one-cycle read latency, pointer held on empty reads.
    assign bus.I_fifo_empty = force_empty || (rd_ptr >= wr_cnt);
    always @(posedge clk) begin
        if (bus.O_fifo_rd && !bus.I_fifo_empty) begin
            bus.I_fifo_rdata <= mem[rd_ptr];
            rd_ptr           <= rd_ptr + 1;
        end
    end

    // Per-cycle output log, sampled mid-cycle.
    always @(negedge clk) begin
        if (cyc < LOGN) begin
            lg_rgb[cyc]  <= o_vid_rgb;
            lg_de[cyc]   <= o_vid_de;
            lg_vs[cyc]   <= o_vid_vs;
            lg_rd[cyc]   <= bus.O_fifo_rd;
            lg_uf[cyc]   <= o_underflow;
            lg_len[cyc]  <= o_len_err;
            lg_freq[cyc] <= o_frame_req;
        end
    end

    task automatic chk(input string tag, input int got, input int exp);
        n_chk++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic vs, input logic hs, input logic de, input logic user,
                         input logic last, input logic emp, input logic r);
        @(posedge clk);
        #1;
        bus.I_vtc_vs   = vs;
        bus.I_vtc_hs   = hs;
        bus.I_vtc_de   = de;
        bus.I_vtc_user = user;
        bus.I_vtc_last = last;
        force_empty    = emp;
        rst            = r;
    endtask

    // One frame: vs pulse, then per line hs, de run and last pulse.
    task automatic run_frame(input int nlines, input int line0_pix, input bit with_user,
                             input int empty_pix, input int rst_pix);
        int k;
        int np;
        k = 0;
        pix_cyc.delete();
        last_cyc.delete();
        drive(1, 0, 0, 0, 0, 0, 0);
        vs_cyc = cyc;
        drive(1, 0, 0, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 0, 0, 0);
        for (int l = 0; l < nlines; l++) begin
            np = (l == 0) ? line0_pix : 4;
            drive(0, 1, 0, 0, 0, 0, 0);
            drive(0, 0, 0, 0, 0, 0, 0);
            for (int p = 0; p < np; p++) begin
                drive(0, 0, 1, logic'(with_user && l == 0 && p == 0), 0,
                      logic'(k == empty_pix), logic'(k == rst_pix));
                pix_cyc.push_back(cyc);
                k++;
            end
            drive(0, 0, 0, 0, 1, 0, 0);
            last_cyc.push_back(cyc);
            drive(0, 0, 0, 0, 0, 0, 0);
        end
        drive(0, 0, 0, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
    endtask

    task automatic chk_frame_data(input string tag, input int base);
        for (int k = 0; k < 8; k++) begin
            chk($sformatf("%s rd%0d", tag, k), int'(lg_rd[pix_cyc[k]]), 1);
            chk($sformatf("%s de%0d", tag, k), int'(lg_de[pix_cyc[k] + 2]), 1);
            chk($sformatf("%s rgb%0d", tag, k), int'(lg_rgb[pix_cyc[k] + 2]), base + k);
        end
    endtask

    initial begin
        int t6_start;
        int t6_end;
        int pulses;
        int c;

        for (int i = 0; i < 128; i++) mem[i] = 24'(i + 1);
        wr_cnt           = 100;
        force_empty      = 1'b0;
        rst              = 1'b1;
        bus.I_vtc_vs     = 1'b0;
        bus.I_vtc_hs     = 1'b0;
        bus.I_vtc_de     = 1'b0;
        bus.I_vtc_user   = 1'b0;
        bus.I_vtc_last   = 1'b0;
        bus.I_fifo_rdata = '0;

        // Reset state
        drive(0, 0, 0, 0, 0, 0, 1);
        drive(0, 0, 0, 0, 0, 0, 1);
        drive(0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        chk("rst rgb", int'(o_vid_rgb), 0);
        chk("rst de", int'(o_vid_de), 0);
        chk("rst vs", int'(o_vid_vs), 0);
        chk("rst hs", int'(o_vid_hs), 0);
        chk("rst rd", int'(bus.O_fifo_rd), 0);
        chk("rst uf", int'(o_underflow), 0);
        chk("rst len", int'(o_len_err), 0);
        chk("rst freq", int'(o_frame_req), 0);

        // Normal 4x2 frame, pixels 1..8
        run_frame(2, 4, 1, -1, -1);
        chk_frame_data("t1", 1);
        chk("t1 vs lat1", int'(lg_vs[vs_cyc + 1]), 0);
        chk("t1 vs lat2", int'(lg_vs[vs_cyc + 2]), 1);
        chk("t1 uf", int'(lg_uf[last_cyc[1] + 1]), 0);
        chk("t1 len", int'(lg_len[last_cyc[1] + 1]), 0);

        // Underflow at pixel 3 of line 0, then recovery
        run_frame(2, 4, 1, 2, -1);
        chk("t2 rgb0", int'(lg_rgb[pix_cyc[0] + 2]), 9);
        chk("t2 rgb1", int'(lg_rgb[pix_cyc[1] + 2]), 10);
        chk("t2 rgb2", int'(lg_rgb[pix_cyc[2] + 2]), 0);
        chk("t2 de2", int'(lg_de[pix_cyc[2] + 2]), 1);
        chk("t2 uf pre", int'(lg_uf[pix_cyc[2]]), 0);
        chk("t2 uf set", int'(lg_uf[pix_cyc[2] + 1]), 1);
        for (int k = 3; k < 8; k++) begin
            chk($sformatf("t2 rd%0d", k), int'(lg_rd[pix_cyc[k]]), 0);
            chk($sformatf("t2 rgb%0d", k), int'(lg_rgb[pix_cyc[k] + 2]), 0);
            chk($sformatf("t2 de%0d", k), int'(lg_de[pix_cyc[k] + 2]), 1);
        end
        chk("t2 uf sticky", int'(lg_uf[last_cyc[1] + 1]), 1);
        run_frame(2, 4, 1, -1, -1);
        chk("t2r uf clr", int'(lg_uf[pix_cyc[0] + 1]), 0);
        chk_frame_data("t2r", 11);

        // Mid-frame start: no reads until the first user pulse
        drive(0, 0, 0, 0, 0, 0, 1);
        run_frame(1, 4, 0, -1, -1);
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("t3 rd%0d", k), int'(lg_rd[pix_cyc[k]]), 0);
            chk($sformatf("t3 rgb%0d", k), int'(lg_rgb[pix_cyc[k] + 2]), 0);
        end
        run_frame(2, 4, 1, -1, -1);
        chk("t3 de lat1", int'(lg_de[pix_cyc[0] + 1]), 0);
        chk_frame_data("t3", 19);

        // Short line (3 of 4 pixels)
        run_frame(2, 3, 1, -1, -1);
        for (int k = 0; k < 3; k++)
            chk($sformatf("t4 rgb%0d", k), int'(lg_rgb[pix_cyc[k] + 2]), 27 + k);
        chk("t4 len pre", int'(lg_len[last_cyc[0]]), 0);
        chk("t4 len set", int'(lg_len[last_cyc[0] + 1]), 1);
        chk("t4 uf", int'(lg_uf[last_cyc[0] + 1]), 0);
        for (int k = 3; k < 7; k++) begin
            chk($sformatf("t4 rd%0d", k), int'(lg_rd[pix_cyc[k]]), 0);
            chk($sformatf("t4 rgb%0d", k), int'(lg_rgb[pix_cyc[k] + 2]), 0);
        end
        run_frame(2, 4, 1, -1, -1);
        chk("t4r len clr", int'(lg_len[pix_cyc[0] + 1]), 0);
        chk_frame_data("t4r", 30);

        // One-cycle reset mid-line at pixel 2
        run_frame(2, 4, 1, -1, 2);
        c = pix_cyc[2];
        chk("t5 rgb0", int'(lg_rgb[c]), 38);
        chk("t5 rd rst", int'(lg_rd[c]), 0);
        chk("t5 de rst", int'(lg_de[c + 1]), 0);
        chk("t5 rgb rst", int'(lg_rgb[c + 1]), 0);
        for (int k = 3; k < 8; k++) begin
            chk($sformatf("t5 rd%0d", k), int'(lg_rd[pix_cyc[k]]), 0);
            chk($sformatf("t5 rgb%0d", k), int'(lg_rgb[pix_cyc[k] + 2]), 0);
            chk($sformatf("t5 de%0d", k), int'(lg_de[pix_cyc[k] + 2]), 1);
        end
        run_frame(2, 4, 1, -1, -1);
        chk_frame_data("t5r", 40);

        // Frame request over three frames
        t6_start = cyc;
        for (int f = 0; f < 3; f++) begin
            run_frame(2, 4, 1, -1, -1);
            chk($sformatf("t6 freq0 f%0d", f), int'(lg_freq[vs_cyc]), 0);
            chk($sformatf("t6 freq1 f%0d", f), int'(lg_freq[vs_cyc + 1]), 1);
            chk($sformatf("t6 freq2 f%0d", f), int'(lg_freq[vs_cyc + 2]), 0);
            chk_frame_data($sformatf("t6 f%0d", f), 48 + 8 * f);
        end
        t6_end = cyc;
        pulses = 0;
        for (int i = t6_start + 1; i <= t6_end; i++)
            if (lg_freq[i]) pulses++;
        chk("t6 pulses", pulses, 3);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end
endmodule

// File: doc/vid_pixel_feeder.md
# vid_pixel_feeder

Downstream consumer of the VTC timing stage. Takes the registered stream-style timing (vs, hs, de, user, last), pops one pixel per active cycle from the DDR3 read-side line FIFO, and emits pixel-aligned RGB plus sync to the HDMI encoder. It owns frame alignment: it locks to the frame-start marker, detects FIFO underflow and line/frame length errors, and blanks the output until the next frame start after any fault.

## Interface
- DATA_W, 24, pixel width (RGB888)
- H_ActiveSize, 1920, expected active pixels per line
- V_ActiveSize, 1080, expected active lines per frame
- BLANK_RGB, 24'h000000, pixel value driven when blanking or faulted
- I_vid_clk  in  1  pixel clock, same clock as the timing generator
- I_vid_rst  in  1  synchronous active-high reset
- I_vtc_vs / I_vtc_hs  in  1 each  sync from the timing generator
- I_vtc_de  in  1  active-pixel valid
- I_vtc_user  in  1  first active pixel of a frame (one-cycle pulse)
- I_vtc_last  in  1  one-cycle pulse on the cycle after the last active pixel of a line
- O_fifo_rd  out  1  FIFO read strobe; data valid one cycle later
- I_fifo_rdata  in  DATA_W  FIFO read data
- I_fifo_empty  in  1  FIFO empty, sampled with O_fifo_rd
- O_frame_req  out  1  one-cycle pulse on the rising edge of I_vtc_vs; requests the next frame from the DDR3 reader
- O_vid_vs / O_vid_hs / O_vid_de  out  1 each  timing aligned to O_vid_rgb
- O_vid_rgb  out  DATA_W  pixel data
- O_underflow  out  1  sticky; set on underflow, cleared at the next accepted frame start
- O_len_err  out  1  sticky; set on line or frame length mismatch, cleared as O_underflow

## Operation
- States: SYNC (reset state), RUN, FAULT.
- SYNC: O_fifo_rd=0, except on a cycle with I_vtc_user=1 and I_vtc_de=1. On that cycle: read, clear both sticky flags, go to RUN.
- RUN: O_fifo_rd = I_vtc_de.
- Underflow: O_fifo_rd=1 while I_fifo_empty=1. The corresponding output pixel is BLANK_RGB, O_underflow is set, and the state goes to FAULT.
- FAULT: O_fifo_rd=0 and every pixel is BLANK_RGB. On I_vtc_user&I_vtc_de, act as SYNC does (re-lock on the same cycle).
- Pixel counter (12 bit): increments on each RUN read. On I_vtc_last, if count ≠ H_ActiveSize, set O_len_err and go to FAULT; in all cases reset the counter to 0.
- Line counter (11 bit): increments on each I_vtc_last in RUN. If I_vtc_user arrives in RUN with line count ≠ V_ActiveSize, set O_len_err and treat the cycle as a re-lock (read and continue in RUN); the counter resets to 0 at user.
- I_vtc_user while in RUN with correct counts: normal frame start.
- Simultaneous underflow and length error in one cycle: both flags set, state FAULT.
- O_frame_req is generated in every state, from an internal registered copy of I_vtc_vs.

## Timing
- Latency input timing → O_vid_*: 2 cycles. Stage 1 is the FIFO read latency with timing delayed 1 cycle; stage 2 is the output register.
- O_vid_rgb: FIFO data when the stage-1 read was valid and not empty; otherwise BLANK_RGB. O_vid_de keeps timing even when blanked.
- Reset values: all outputs 0; O_vid_rgb = BLANK_RGB; state SYNC; counters 0.
- Reset asserted mid-frame: outputs return to reset values on the next edge. Do not read until the next user pulse after release.
- O_frame_req: exactly 1 cycle, 1 cycle after I_vtc_vs rises.

## Structure
- Shared package: state encoding (SYNC/RUN/FAULT), BLANK_RGB default, counter widths.
- One natural sub-module: vid_align_pipe, a 2-stage delay line for vs/hs/de plus a read-valid tag.
- The FSM and counters stay in the top module.

## Test plan
- Reset, then a 4×2 frame (H=4, V=2) from a prefilled FIFO holding 8 pixels 1..8. O_vid_rgb shows 1..8 exactly 2 cycles after each de; no flags set.
- FIFO empty at pixel 3 of line 0. Output pixel 3 = BLANK_RGB, O_underflow=1, all later pixels blank with O_fifo_rd=0. On the next frame's user pulse: O_underflow clears and data resumes.
- Start stimulus mid-frame (no user seen). No reads and blank output until the first user pulse; then the first pixel appears 2 cycles later.
- Drive a 3-pixel line with H_ActiveSize=4. O_len_err=1 on the cycle after the last pulse, state FAULT, recovery at the next frame.
- Assert I_vid_rst for 1 cycle mid-line. All outputs reset on the next edge; O_fifo_rd stays 0 until user.
- Toggle I_vtc_vs over 3 frames. Exactly 3 single-cycle O_frame_req pulses, each 1 cycle after a vs rising edge.
